// File: rtl/frog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frog_pkg
// Description : Shared sizes, counter type and FSM states for frog/log
//               collision detection.
// Revision    : 1.0 - initial release
// ============================================================================
package frog_pkg;

    localparam int NUM_OF_LOGS = 2;
    localparam int CNT_W       = 16;
    localparam int LOG_IDX_W   = (NUM_OF_LOGS > 1) ? $clog2(NUM_OF_LOGS) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        SCAN     = 2'd1,
        EVAL     = 2'd2,
        REPORT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear (clear wins).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/frog_log_collision.sv
`default_nettype none
// ============================================================================
// Module      : frog_log_collision
// Description : Per-frame frog/log/water overlap counting; reports log riding
//               and a debounced drown pulse after each frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module frog_log_collision
    import frog_pkg::*;
#(
    parameter int LOG_THRESH   = 16,
    parameter int WATER_THRESH = 32,
    parameter int DROWN_FRAMES = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   startOfFrame,
    input  logic                   frog_draw_req,
    input  logic [NUM_OF_LOGS-1:0] log_draw_req,
    input  logic                   water_draw_req,
    output logic                   on_log,
    output logic [LOG_IDX_W-1:0]   log_index,
    output logic                   frog_drowned,
    output logic                   result_valid
);

    localparam int                 c_wet_w        = $clog2(DROWN_FRAMES + 1);
    localparam cnt_t               c_log_thresh   = cnt_t'(LOG_THRESH);
    localparam cnt_t               c_water_thresh = cnt_t'(WATER_THRESH);
    localparam logic [c_wet_w-1:0] c_drown        = c_wet_w'(DROWN_FRAMES);
    localparam logic [c_wet_w-1:0] c_drown_m1     = c_wet_w'(DROWN_FRAMES - 1);

    state_t                 r_state;
    logic [NUM_OF_LOGS-1:0] r_hit;
    logic [NUM_OF_LOGS-1:0] r_snap_hit;
    cnt_t                   r_snap_frog;
    cnt_t                   r_snap_log;
    cnt_t                   r_snap_water;
    logic [c_wet_w-1:0]     r_wet_cnt;

    cnt_t                   w_frog_pix;
    cnt_t                   w_log_pix;
    cnt_t                   w_water_pix;
    logic                   w_sof_take;
    logic                   w_scan;
    logic                   w_frog_log;
    logic                   w_frog_water;
    logic                   w_ride;
    logic                   w_wet;
    logic [LOG_IDX_W-1:0]   w_idx;

    // A frame boundary is only honoured while waiting or scanning.
    assign w_sof_take   = startOfFrame && ((r_state == WAIT_SOF) || (r_state == SCAN));
    assign w_scan       = (r_state == SCAN) && !startOfFrame;
    assign w_frog_log   = w_scan && frog_draw_req && (|log_draw_req);
    assign w_frog_water = w_scan && frog_draw_req && !(|log_draw_req) && water_draw_req;

    sat_counter #(.WIDTH(CNT_W)) u_frog_cnt (
        .clk(CLK), .rst(RESET), .i_clr(w_sof_take),
        .i_inc(w_scan && frog_draw_req), .o_count(w_frog_pix)
    );

    sat_counter #(.WIDTH(CNT_W)) u_log_cnt (
        .clk(CLK), .rst(RESET), .i_clr(w_sof_take),
        .i_inc(w_frog_log), .o_count(w_log_pix)
    );

    sat_counter #(.WIDTH(CNT_W)) u_water_cnt (
        .clk(CLK), .rst(RESET), .i_clr(w_sof_take),
        .i_inc(w_frog_water), .o_count(w_water_pix)
    );

    always_comb begin
        w_ride = (r_snap_frog != '0) && (r_snap_log >= c_log_thresh);
        w_wet  = (r_snap_frog != '0) && !w_ride && (r_snap_water >= c_water_thresh);
        w_idx  = '0;
        // Scan downwards so the lowest-index hit is the one that sticks.
        for (int i = NUM_OF_LOGS - 1; i >= 0; i--) begin
            if (r_snap_hit[i]) begin
                w_idx = LOG_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= WAIT_SOF;
            r_hit        <= '0;
            r_snap_hit   <= '0;
            r_snap_frog  <= '0;
            r_snap_log   <= '0;
            r_snap_water <= '0;
            r_wet_cnt    <= '0;
            on_log       <= 1'b0;
            log_index    <= '0;
            frog_drowned <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            frog_drowned <= 1'b0;
            case (r_state)
                WAIT_SOF: begin
                    if (startOfFrame) begin
                        r_hit   <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (startOfFrame) begin
                        r_snap_frog  <= w_frog_pix;
                        r_snap_log   <= w_log_pix;
                        r_snap_water <= w_water_pix;
                        r_snap_hit   <= r_hit;
                        r_hit        <= '0;
                        r_state      <= EVAL;
                    end else if (w_frog_log) begin
                        r_hit <= r_hit | log_draw_req;
                    end
                end
                EVAL: begin
                    result_valid <= 1'b1;
                    on_log       <= w_ride;
                    log_index    <= w_ride ? w_idx : '0;
                    if (w_wet) begin
                        if (r_wet_cnt != c_drown) begin
                            r_wet_cnt <= r_wet_cnt + c_wet_w'(1);
                        end
                        frog_drowned <= (r_wet_cnt == c_drown_m1);
                    end else begin
                        r_wet_cnt <= '0;
                    end
                    r_state <= REPORT;
                end
                REPORT: begin
                    r_state <= SCAN;
                end
                default: begin
                    r_state <= WAIT_SOF;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
